// File: rtl/ysyx_24080006_ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one 32-bit read per instruction and hands {pc, inst, fault} to decode.
// Latency: REQ -> RESP -> HOLD -> WAITPC, so four cycles per instruction with zero-wait partners; one instruction in flight.
// Backpressure: stalls in REQ on arready, RESP on rvalid, HOLD on idu_ready and WAITPC on npc_valid; bundle fields stay frozen in HOLD.
//
// Ports:
//   clock, reset          single clock; asynchronous active-high reset
//   araddr/arvalid/arready read address channel (araddr is the PC register)
//   rdata/rresp/rvalid/rready read data channel (rresp 2'b00 = OKAY)
//   idu_valid/idu_ready   bundle handshake to decode; idu_pc/idu_inst/idu_fault are the bundle
//   npc_valid/npc/npc_ready next-PC handshake from execute/write-back
//   fetch_cnt             number of bundles accepted by decode (wraps)
module ysyx_24080006_ifu_fetch #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clock,
   input  logic              reset,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [31:0]       rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic              idu_valid,
   input  logic              idu_ready,
   output logic [ADDR_W-1:0] idu_pc,
   output logic [31:0]       idu_inst,
   output logic              idu_fault,
   input  logic              npc_valid,
   input  logic [ADDR_W-1:0] npc,
   output logic              npc_ready,
   output logic [31:0]       fetch_cnt
);

   typedef enum logic [2:0] {
      BOOT   = 3'd0,
      REQ    = 3'd1,
      RESP   = 3'd2,
      HOLD   = 3'd3,
      WAITPC = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic              pc_misaligned;

   assign pc_misaligned = (pc[1:0] != 2'b00);

   // Handshake outputs are pure decodes of the state register, so an
   // asynchronous reset drops them immediately.
   assign arvalid   = (state == REQ) && !pc_misaligned;
   assign rready    = (state == RESP);
   assign idu_valid = (state == HOLD);
   assign npc_ready = (state == WAITPC);
   assign araddr    = pc;
   assign idu_pc    = pc;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         idu_inst  <= 32'h0;
         idu_fault <= 1'b0;
         fetch_cnt <= 32'h0;
      end else begin
         case (state)
            BOOT: begin
               state <= REQ;
            end
            REQ: begin
               // A misaligned PC never reaches the bus; it turns straight
               // into a faulting bundle.
               if (pc_misaligned) begin
                  idu_inst  <= 32'h0;
                  idu_fault <= 1'b1;
                  state     <= HOLD;
               end else if (arready) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (rvalid) begin
                  if (rresp != 2'b00) begin
                     idu_inst  <= 32'h0;
                     idu_fault <= 1'b1;
                  end else begin
                     idu_inst  <= rdata;
                     idu_fault <= 1'b0;
                  end
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (idu_ready) begin
                  fetch_cnt <= fetch_cnt + 32'd1;
                  state     <= WAITPC;
               end
            end
            WAITPC: begin
               if (npc_valid) begin
                  pc    <= npc;
                  state <= REQ;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_ifu_fetch.sv
module tb_ysyx_24080006_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        idu_valid;
   logic        idu_ready = 1'b0;
   logic [31:0] idu_pc;
   logic [31:0] idu_inst;
   logic        idu_fault;
   logic        npc_valid = 1'b0;
   logic [31:0] npc = 32'h0;
   logic        npc_ready;
   logic [31:0] fetch_cnt;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: architectural PC and count of accepted bundles.
   logic [31:0] mdl_pc;
   logic [31:0] mdl_cnt;

   ysyx_24080006_ifu_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
      .clock(clock), .reset(reset),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_pc(idu_pc),
      .idu_inst(idu_inst), .idu_fault(idu_fault),
      .npc_valid(npc_valid), .npc(npc), .npc_ready(npc_ready),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_arvalid"}, {31'b0, arvalid}, 32'd0);
      chk({tag, "_rready"}, {31'b0, rready}, 32'd0);
      chk({tag, "_idu_valid"}, {31'b0, idu_valid}, 32'd0);
      chk({tag, "_npc_ready"}, {31'b0, npc_ready}, 32'd0);
      chk({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
      chk({tag, "_idu_pc"}, idu_pc, RST_PC);
      chk({tag, "_idu_inst"}, idu_inst, 32'd0);
      chk({tag, "_idu_fault"}, {31'b0, idu_fault}, 32'd0);
   endtask

   // One complete instruction. Entered just after the edge that put the
   // DUT in REQ; leaves just after the edge that takes the next PC.
   task automatic fetch(input int arw, input int rw, input int hw, input int nw,
                        input logic [1:0] resp, input logic [31:0] data,
                        input logic [31:0] nxt);
      logic [31:0] exp_inst;
      logic        exp_fault;
      if (mdl_pc[1:0] != 2'b00) begin
         @(negedge clock);
         chk("mis_arvalid", {31'b0, arvalid}, 32'd0);
         chk("mis_rready", {31'b0, rready}, 32'd0);
         npc_valid = 1'b0; arready = 1'($urandom); rvalid = 1'($urandom);
         idu_ready = 1'($urandom);
         @(posedge clock);
         exp_inst = 32'h0; exp_fault = 1'b1;
      end else begin
         for (int i = 0; i <= arw; i++) begin
            @(negedge clock);
            chk("req_arvalid", {31'b0, arvalid}, 32'd1);
            chk("req_araddr", araddr, mdl_pc);
            chk("req_rready", {31'b0, rready}, 32'd0);
            chk("req_npc_ready", {31'b0, npc_ready}, 32'd0);
            npc_valid = 1'b0;
            arready   = (i == arw);
            rvalid    = 1'($urandom);
            rdata     = $urandom;
            rresp     = 2'($urandom);
            idu_ready = 1'($urandom);
            @(posedge clock);
         end
         for (int i = 0; i <= rw; i++) begin
            @(negedge clock);
            chk("resp_rready", {31'b0, rready}, 32'd1);
            chk("resp_arvalid", {31'b0, arvalid}, 32'd0);
            chk("resp_idu_valid", {31'b0, idu_valid}, 32'd0);
            arready   = 1'($urandom);
            rvalid    = (i == rw);
            rdata     = (i == rw) ? data : $urandom;
            rresp     = resp;
            idu_ready = 1'($urandom);
            npc_valid = 1'($urandom);
            npc       = $urandom;
            @(posedge clock);
         end
         exp_fault = (resp != 2'b00);
         exp_inst  = exp_fault ? 32'h0 : data;
      end
      for (int i = 0; i <= hw; i++) begin
         @(negedge clock);
         chk("hold_idu_valid", {31'b0, idu_valid}, 32'd1);
         chk("hold_idu_pc", idu_pc, mdl_pc);
         chk("hold_idu_inst", idu_inst, exp_inst);
         chk("hold_idu_fault", {31'b0, idu_fault}, {31'b0, exp_fault});
         chk("hold_fetch_cnt", fetch_cnt, mdl_cnt);
         chk("hold_npc_ready", {31'b0, npc_ready}, 32'd0);
         chk("hold_arvalid", {31'b0, arvalid}, 32'd0);
         rvalid    = 1'b0;
         arready   = 1'($urandom);
         idu_ready = (i == hw);
         npc_valid = 1'($urandom);
         npc       = $urandom;
         @(posedge clock);
      end
      mdl_cnt = mdl_cnt + 32'd1;
      for (int i = 0; i <= nw; i++) begin
         @(negedge clock);
         chk("wpc_npc_ready", {31'b0, npc_ready}, 32'd1);
         chk("wpc_idu_valid", {31'b0, idu_valid}, 32'd0);
         chk("wpc_arvalid", {31'b0, arvalid}, 32'd0);
         chk("wpc_fetch_cnt", fetch_cnt, mdl_cnt);
         chk("wpc_idu_pc", idu_pc, mdl_pc);
         idu_ready = 1'($urandom);
         npc_valid = (i == nw);
         npc       = (i == nw) ? nxt : $urandom;
         @(posedge clock);
      end
      mdl_pc = nxt;
   endtask

   // Start a fetch, reach RESP, then pull reset while the read is outstanding.
   task automatic abort_in_resp();
      @(negedge clock);
      chk("abort_req_arvalid", {31'b0, arvalid}, 32'd1);
      arready = 1'b1; rvalid = 1'b0; npc_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("abort_resp_rready", {31'b0, rready}, 32'd1);
      arready = 1'b0;
      reset   = 1'b1;
      #1;
      chk_idle_reset("abort_async");
      @(posedge clock);
      @(negedge clock);
      chk_idle_reset("abort_held");
      reset = 1'b0;
      mdl_pc  = RST_PC;
      mdl_cnt = 32'd0;
      #1;
      chk("boot_arvalid2", {31'b0, arvalid}, 32'd0);
      @(posedge clock);
   endtask

   logic [31:0] nxt;
   logic [1:0]  rsp;

   initial begin
      mdl_pc  = RST_PC;
      mdl_cnt = 32'd0;
      repeat (2) @(negedge clock);
      chk_idle_reset("reset");
      reset = 1'b0;
      #1;
      chk("boot_arvalid", {31'b0, arvalid}, 32'd0);
      @(posedge clock);

      // Zero-wait first fetch, then the 0x8000_0004 / 0x8000_0010 sequence.
      fetch(0, 0, 0, 0, 2'b00, 32'h0010_0093, 32'h8000_0004);
      fetch(3, 0, 0, 0, 2'b00, 32'h1234_5678, 32'h8000_0010);
      fetch(0, 1, 5, 2, 2'b00, 32'hCAFE_F00D, 32'h8000_0102);
      fetch(0, 0, 0, 0, 2'b00, 32'h0, 32'h8000_0020);
      fetch(0, 0, 1, 0, 2'b10, 32'hDEAD_BEEF, 32'h8000_0024);
      abort_in_resp();
      fetch(0, 0, 0, 0, 2'b00, 32'h0000_0013, 32'h8000_0008);

      for (int k = 0; k < 60; k++) begin
         nxt = RST_PC + {22'b0, 8'($urandom), 2'b00};
         if ($urandom_range(0, 7) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
         rsp = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
         fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), rsp, $urandom, nxt);
      end

      @(negedge clock);
      chk("final_fetch_cnt", fetch_cnt, mdl_cnt);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
